// File: rtl/ycbcr_to_rgb_ctrl.sv
// ycbcr_to_rgb_ctrl
// Sequencer for the YCbCr->RGB conversion stage. Reads each pixel of the YCbCr
// frame memory and registers the Y/Cb/Cr words onto the converter inputs. It holds
// them for a settle window, then writes the converter results into the RGB frame
// memory. When the last pixel has been written it raises en_mem_RGB for the
// downstream stage.
//
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   start                  - begin a frame (sampled in IDLE only)
//   busy, done, en_mem_RGB - frame status: busy level, done pulse, downstream enable
//   rd_en, rd_addr         - YCbCr memory read strobe / address
//   rd_Y, rd_Cb, rd_Cr     - YCbCr read data, valid MEM_LAT cycles after rd_en
//   cv_Y, cv_Cb, cv_Cr     - registered operands to the FP converters
//   cv_R, cv_G, cv_B       - converter results
//   wr_en, wr_ready        - RGB memory write request / accept
//   wr_addr, wr_R/G/B      - RGB write address and registered results
module ycbcr_to_rgb_ctrl #(
    parameter int unsigned NUM_PIX    = 4096,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              en_mem_RGB,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_Y,
    input  logic [31:0]       rd_Cb,
    input  logic [31:0]       rd_Cr,
    output logic [31:0]       cv_Y,
    output logic [31:0]       cv_Cb,
    output logic [31:0]       cv_Cr,
    input  logic [31:0]       cv_R,
    input  logic [31:0]       cv_G,
    input  logic [31:0]       cv_B,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_R,
    output logic [31:0]       wr_G,
    output logic [31:0]       wr_B
);

    // One down-counter serves both the LAT and the SET windows.
    localparam int unsigned CNT_MAX = (MEM_LAT > SETTLE_CYC) ? MEM_LAT : SETTLE_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);
    localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0]  SET_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {IDLE, RD, LAT, SET, WR, FIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pix, pix_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              ld_cv, ld_wr, accept, frame_end;

    always_comb begin
        state_next = state;
        pix_next   = pix;
        cnt_next   = cnt;
        ld_cv      = 1'b0;
        ld_wr      = 1'b0;
        accept     = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    pix_next   = '0;
                    state_next = RD;
                end
            end
            RD: begin
                cnt_next   = LAT_LOAD;
                state_next = LAT;
            end
            LAT: begin
                if (cnt == '0) begin
                    ld_cv      = 1'b1;
                    cnt_next   = SET_LOAD;
                    state_next = SET;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            SET: begin
                if (cnt == '0) begin
                    ld_wr      = 1'b1;
                    state_next = WR;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            WR: begin
                // Request stays up with stable data until the memory takes it.
                if (wr_ready) begin
                    if (pix == LAST_PIX) begin
                        frame_end  = 1'b1;
                        state_next = FIN;
                    end else begin
                        pix_next   = pix + ADDR_W'(1);
                        state_next = RD;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pix        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            en_mem_RGB <= 1'b0;
            cv_Y       <= '0;
            cv_Cb      <= '0;
            cv_Cr      <= '0;
            wr_R       <= '0;
            wr_G       <= '0;
            wr_B       <= '0;
        end else begin
            state <= state_next;
            pix   <= pix_next;
            cnt   <= cnt_next;
            if (accept) begin
                busy       <= 1'b1;
                en_mem_RGB <= 1'b0;
            end else if (state == FIN) begin
                busy <= 1'b0;
            end
            // Set on the edge into FIN so it rises together with done.
            if (frame_end) begin
                en_mem_RGB <= 1'b1;
            end
            // cv_* only change on capture, keeping converter inputs quiet otherwise.
            if (ld_cv) begin
                cv_Y  <= rd_Y;
                cv_Cb <= rd_Cb;
                cv_Cr <= rd_Cr;
            end
            if (ld_wr) begin
                wr_R <= cv_R;
                wr_G <= cv_G;
                wr_B <= cv_B;
            end
        end
    end

    assign rd_en   = (state == RD);
    assign wr_en   = (state == WR);
    assign done    = (state == FIN);
    assign rd_addr = pix;
    assign wr_addr = pix;

endmodule

// File: tb/tb_ycbcr_to_rgb_ctrl.sv
`timescale 1ns/1ps
module tb_ycbcr_to_rgb_ctrl;

    localparam int NP   = 4;
    localparam int AW   = 3;
    localparam int ML_A = 1;
    localparam int SC_A = 4;
    localparam int ML_B = 3;
    localparam int SC_B = 1;
    localparam int LAT_A = NP * (2 + ML_A + SC_A) + 1;
    localparam int LAT_B = NP * (2 + ML_B + SC_B) + 1;
    localparam logic [31:0] JUNK = 32'hDEAD_0000;
    localparam logic [31:0] BAD  = 32'hBAD0_0000;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   r;
        logic [31:0]   g;
        logic [31:0]   b;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_y [NP];
    logic [31:0] mem_cb[NP];
    logic [31:0] mem_cr[NP];

    // Behavioural converter functions (integer stand-ins for the FP datapaths).
    function automatic logic [31:0] conv_r(logic [31:0] y, logic [31:0] cb, logic [31:0] cr);
        return y + 32'd3 * cr + (cb ^ cb);
    endfunction
    function automatic logic [31:0] conv_g(logic [31:0] y, logic [31:0] cb, logic [31:0] cr);
        return y - cb - cr;
    endfunction
    function automatic logic [31:0] conv_b(logic [31:0] y, logic [31:0] cb, logic [31:0] cr);
        return y + 32'd5 * cb + (cr ^ cr);
    endfunction

    // Reference: the write expected for pixel a of the frame.
    function automatic wr_t exp_write(int a);
        wr_t w;
        w.addr = AW'(a);
        w.r = conv_r(mem_y[a], mem_cb[a], mem_cr[a]);
        w.g = conv_g(mem_y[a], mem_cb[a], mem_cr[a]);
        w.b = conv_b(mem_y[a], mem_cb[a], mem_cr[a]);
        return w;
    endfunction

    // ---------------- DUT A: MEM_LAT=1, SETTLE_CYC=4 ----------------
    logic start_a, busy_a, done_a, en_a, rd_en_a, wr_en_a, wr_ready_a;
    logic [AW-1:0] rd_addr_a, wr_addr_a;
    logic [31:0] rd_y_a, rd_cb_a, rd_cr_a, cv_y_a, cv_cb_a, cv_cr_a;
    logic [31:0] cv_r_a, cv_g_a, cv_b_a, wr_r_a, wr_g_a, wr_b_a;

    ycbcr_to_rgb_ctrl #(.NUM_PIX(NP), .ADDR_W(AW), .MEM_LAT(ML_A), .SETTLE_CYC(SC_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .en_mem_RGB(en_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_Y(rd_y_a), .rd_Cb(rd_cb_a), .rd_Cr(rd_cr_a),
        .cv_Y(cv_y_a), .cv_Cb(cv_cb_a), .cv_Cr(cv_cr_a),
        .cv_R(cv_r_a), .cv_G(cv_g_a), .cv_B(cv_b_a),
        .wr_en(wr_en_a), .wr_ready(wr_ready_a), .wr_addr(wr_addr_a),
        .wr_R(wr_r_a), .wr_G(wr_g_a), .wr_B(wr_b_a)
    );

    // ---------------- DUT B: MEM_LAT=3, SETTLE_CYC=1 ----------------
    logic start_b, busy_b, done_b, en_b, rd_en_b, wr_en_b, wr_ready_b;
    logic [AW-1:0] rd_addr_b, wr_addr_b;
    logic [31:0] rd_y_b, rd_cb_b, rd_cr_b, cv_y_b, cv_cb_b, cv_cr_b;
    logic [31:0] cv_r_b, cv_g_b, cv_b_b, wr_r_b, wr_g_b, wr_b_b;

    ycbcr_to_rgb_ctrl #(.NUM_PIX(NP), .ADDR_W(AW), .MEM_LAT(ML_B), .SETTLE_CYC(SC_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .en_mem_RGB(en_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_Y(rd_y_b), .rd_Cb(rd_cb_b), .rd_Cr(rd_cr_b),
        .cv_Y(cv_y_b), .cv_Cb(cv_cb_b), .cv_Cr(cv_cr_b),
        .cv_R(cv_r_b), .cv_G(cv_g_b), .cv_B(cv_b_b),
        .wr_en(wr_en_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b),
        .wr_R(wr_r_b), .wr_G(wr_g_b), .wr_B(wr_b_b)
    );

    // Memory models: data is valid only in the exact cycle MEM_LAT after rd_en.
    logic          pa_v;
    logic [AW-1:0] pa_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) pa_v <= 1'b0;
        else begin
            pa_v    <= rd_en_a;
            pa_addr <= rd_addr_a;
        end
    end
    assign rd_y_a  = pa_v ? mem_y[pa_addr[1:0]]  : JUNK;
    assign rd_cb_a = pa_v ? mem_cb[pa_addr[1:0]] : (JUNK ^ 32'd1);
    assign rd_cr_a = pa_v ? mem_cr[pa_addr[1:0]] : (JUNK ^ 32'd2);

    logic [2:0]    pb_v;
    logic [AW-1:0] pb_a0, pb_a1, pb_a2;
    always @(posedge clk or posedge rst) begin
        if (rst) pb_v <= '0;
        else begin
            pb_v  <= {pb_v[1:0], rd_en_b};
            pb_a0 <= rd_addr_b;
            pb_a1 <= pb_a0;
            pb_a2 <= pb_a1;
        end
    end
    assign rd_y_b  = pb_v[2] ? mem_y[pb_a2[1:0]]  : JUNK;
    assign rd_cb_b = pb_v[2] ? mem_cb[pb_a2[1:0]] : (JUNK ^ 32'd1);
    assign rd_cr_b = pb_v[2] ? mem_cr[pb_a2[1:0]] : (JUNK ^ 32'd2);

    // Converter models: results are garbage until operands have been stable
    // for SETTLE_CYC cycles.
    logic [95:0] last_a = '0, last_b = '0;
    int age_a = 0, age_b = 0;
    always @(negedge clk) begin
        if ({cv_y_a, cv_cb_a, cv_cr_a} != last_a) begin
            last_a <= {cv_y_a, cv_cb_a, cv_cr_a};
            age_a  <= 1;
        end else if (age_a < 1000) age_a <= age_a + 1;
        if ({cv_y_b, cv_cb_b, cv_cr_b} != last_b) begin
            last_b <= {cv_y_b, cv_cb_b, cv_cr_b};
            age_b  <= 1;
        end else if (age_b < 1000) age_b <= age_b + 1;
    end
    assign cv_r_a = (age_a >= SC_A) ? conv_r(cv_y_a, cv_cb_a, cv_cr_a) : BAD;
    assign cv_g_a = (age_a >= SC_A) ? conv_g(cv_y_a, cv_cb_a, cv_cr_a) : BAD;
    assign cv_b_a = (age_a >= SC_A) ? conv_b(cv_y_a, cv_cb_a, cv_cr_a) : BAD;
    assign cv_r_b = (age_b >= SC_B) ? conv_r(cv_y_b, cv_cb_b, cv_cr_b) : BAD;
    assign cv_g_b = (age_b >= SC_B) ? conv_g(cv_y_b, cv_cb_b, cv_cr_b) : BAD;
    assign cv_b_b = (age_b >= SC_B) ? conv_b(cv_y_b, cv_cb_b, cv_cr_b) : BAD;

    // Write monitors (sampled mid-low-phase, inputs and outputs both stable).
    wr_t  wq_a[$];
    wr_t  wq_b[$];
    wr_t  held_a;
    logic prev_stall_a = 1'b0;
    int   stall_a = 0, hold_err_a = 0;
    always begin
        @(negedge clk);
        #1;
        if (!rst && prev_stall_a &&
            (!wr_en_a || {wr_addr_a, wr_r_a, wr_g_a, wr_b_a} != held_a)) hold_err_a++;
        prev_stall_a = wr_en_a && !wr_ready_a;
        if (prev_stall_a) begin
            stall_a++;
            held_a = {wr_addr_a, wr_r_a, wr_g_a, wr_b_a};
        end
        if (wr_en_a && wr_ready_a) wq_a.push_back({wr_addr_a, wr_r_a, wr_g_a, wr_b_a});
        if (wr_en_b && wr_ready_b) wq_b.push_back({wr_addr_b, wr_r_b, wr_g_b, wr_b_b});
    end

    wire any_out_a = |{busy_a, done_a, en_a, rd_en_a, wr_en_a, rd_addr_a, wr_addr_a,
                       cv_y_a, cv_cb_a, cv_cr_a, wr_r_a, wr_g_a, wr_b_a};
    wire any_out_b = |{busy_b, done_b, en_b, rd_en_b, wr_en_b, rd_addr_b, wr_addr_b,
                       cv_y_b, cv_cb_b, cv_cr_b, wr_r_b, wr_g_b, wr_b_b};

    task automatic randomize_mem();
        for (int i = 0; i < NP; i++) begin
            mem_y[i]  = $urandom();
            mem_cb[i] = $urandom();
            mem_cr[i] = $urandom();
        end
    endtask

    // Drive a one-cycle start; returns at the falling edge of cycle 1 (RD).
    task automatic start_frame(input bit sel_b);
        @(negedge clk);
        if (sel_b) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // lat = index of the cycle (current cycle = 1) in which done is seen, -1 on timeout.
    task automatic wait_done(input bit sel_b, input int bound, output int lat);
        lat = -1;
        #1;
        for (int k = 1; k <= bound; k++) begin
            if ((sel_b ? done_b : done_a) === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic seen;
        #2;
        vectors++;
        if ((any_out_a | any_out_b) !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state outputs_nonzero got %b want 0", any_out_a | any_out_b);
        end
        @(negedge clk);
        rst = 1'b0;
        randomize_mem();
        start_frame(0);
        repeat (9) @(negedge clk);
        #1;
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_busy got %b want 1", busy_a);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (any_out_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async outputs got %b want 0 (cv_y=%h)", any_out_a, cv_y_a);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            seen = seen | rd_en_a | wr_en_a | busy_a | done_a;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet activity got %b want 0", seen);
        end
    endtask

    task automatic test_frame();
        int lat;
        randomize_mem();
        wq_a.delete();
        start_frame(0);
        wait_done(0, 200, lat);
        vectors++;
        if (lat != LAT_A) begin
            miscompares++;
            $display("FAIL frame_latency got %0d want %0d", lat, LAT_A);
        end
        vectors++;
        if (en_a !== 1'b1 || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_fin_flags got en=%b busy=%b want en=1 busy=1", en_a, busy_a);
        end
        vectors++;
        if (wq_a.size() != NP) begin
            miscompares++;
            $display("FAIL frame_wr_count got %0d want %0d", wq_a.size(), NP);
        end
        for (int i = 0; i < NP && i < wq_a.size(); i++) begin
            vectors++;
            if (wq_a[i] !== exp_write(i)) begin
                miscompares++;
                $display("FAIL frame_wr[%0d] got %h want %h", i, wq_a[i], exp_write(i));
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (busy_a !== 1'b0 || en_a !== 1'b1 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_after got busy=%b en=%b done=%b want 0 1 0",
                     busy_a, en_a, done_a);
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        randomize_mem();
        wq_a.delete();
        stall_a = 0;
        hold_err_a = 0;
        lat = -1;
        fork
            begin
                start_frame(0);
                wait_done(0, 200, lat);
            end
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (wr_en_a && wr_addr_a == AW'(2)) begin
                        wr_ready_a = 1'b0;
                        repeat (3) @(negedge clk);
                        wr_ready_a = 1'b1;
                        break;
                    end
                end
            end
        join
        vectors++;
        if (lat != LAT_A + 3) begin
            miscompares++;
            $display("FAIL bp_latency got %0d want %0d", lat, LAT_A + 3);
        end
        vectors++;
        if (stall_a != 3 || hold_err_a != 0) begin
            miscompares++;
            $display("FAIL bp_hold got stalls=%0d hold_errs=%0d want 3 0", stall_a, hold_err_a);
        end
        vectors++;
        if (wq_a.size() != NP) begin
            miscompares++;
            $display("FAIL bp_wr_count got %0d want %0d", wq_a.size(), NP);
        end
        for (int i = 0; i < NP && i < wq_a.size(); i++) begin
            vectors++;
            if (wq_a[i] !== exp_write(i)) begin
                miscompares++;
                $display("FAIL bp_wr[%0d] got %h want %h", i, wq_a[i], exp_write(i));
            end
        end
    endtask

    task automatic test_latency_params();
        int lat;
        randomize_mem();
        wq_b.delete();
        start_frame(1);
        wait_done(1, 200, lat);
        vectors++;
        if (lat != LAT_B) begin
            miscompares++;
            $display("FAIL lat_b_latency got %0d want %0d", lat, LAT_B);
        end
        vectors++;
        if (en_b !== 1'b1) begin
            miscompares++;
            $display("FAIL lat_b_en got %b want 1", en_b);
        end
        vectors++;
        if (wq_b.size() != NP) begin
            miscompares++;
            $display("FAIL lat_b_wr_count got %0d want %0d", wq_b.size(), NP);
        end
        for (int i = 0; i < NP && i < wq_b.size(); i++) begin
            vectors++;
            if (wq_b[i] !== exp_write(i)) begin
                miscompares++;
                $display("FAIL lat_b_wr[%0d] got %h want %h", i, wq_b[i], exp_write(i));
            end
        end
    endtask

    task automatic test_start_handling();
        int   lat;
        logic seen, en_ok;
        randomize_mem();
        wq_a.delete();
        start_frame(0);
        repeat (3) @(negedge clk);
        start_a = 1'b1;          // cycle 4: pixel 0 is settling
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, 200, lat);
        vectors++;
        if (lat + 4 != LAT_A) begin
            miscompares++;
            $display("FAIL start_ignore_latency got %0d want %0d", lat + 4, LAT_A);
        end
        start_a = 1'b1;          // during FIN
        @(negedge clk);
        start_a = 1'b0;
        seen  = 1'b0;
        en_ok = 1'b1;
        repeat (5) begin
            #1;
            seen  = seen | rd_en_a | busy_a | wr_en_a;
            en_ok = en_ok & en_a;
            @(negedge clk);
        end
        vectors++;
        if (seen !== 1'b0 || en_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_fin got active=%b en=%b want 0 1", seen, en_ok);
        end
        vectors++;
        if (wq_a.size() != NP) begin
            miscompares++;
            $display("FAIL start_wr_count got %0d want %0d", wq_a.size(), NP);
        end
        randomize_mem();
        wq_a.delete();
        start_frame(0);
        #1;
        vectors++;
        if (en_a !== 1'b0 || rd_en_a !== 1'b1 || rd_addr_a !== AW'(0) || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL restart got en=%b rd_en=%b addr=%0d busy=%b want 0 1 0 1",
                     en_a, rd_en_a, rd_addr_a, busy_a);
        end
        wait_done(0, 200, lat);
        vectors++;
        if (wq_a.size() != NP) begin
            miscompares++;
            $display("FAIL restart_wr_count got %0d want %0d", wq_a.size(), NP);
        end
        for (int i = 0; i < NP && i < wq_a.size(); i++) begin
            vectors++;
            if (wq_a[i] !== exp_write(i)) begin
                miscompares++;
                $display("FAIL restart_wr[%0d] got %h want %h", i, wq_a[i], exp_write(i));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int   lat;
        bit   hit;
        logic seen;
        randomize_mem();
        wq_a.delete();
        start_frame(0);
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (wr_en_a && wr_addr_a == AW'(1)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (hit !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_reach_wr1 got %b want 1", hit);
        end
        wr_ready_a = 1'b0;
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (any_out_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs got %b want 0", any_out_a);
        end
        @(negedge clk);
        #3;
        rst = 1'b0;
        wr_ready_a = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            #1;
            seen = seen | busy_a | rd_en_a | wr_en_a;
        end
        vectors++;
        if (wq_a.size() != 1 || seen !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_abandon got writes=%0d active=%b want 1 0", wq_a.size(), seen);
        end
        randomize_mem();
        wq_a.delete();
        start_frame(0);
        wait_done(0, 200, lat);
        vectors++;
        if (lat != LAT_A) begin
            miscompares++;
            $display("FAIL midrst_relatency got %0d want %0d", lat, LAT_A);
        end
        vectors++;
        if (wq_a.size() != NP) begin
            miscompares++;
            $display("FAIL midrst_wr_count got %0d want %0d", wq_a.size(), NP);
        end
        for (int i = 0; i < NP && i < wq_a.size(); i++) begin
            vectors++;
            if (wq_a[i] !== exp_write(i)) begin
                miscompares++;
                $display("FAIL midrst_wr[%0d] got %h want %h", i, wq_a[i], exp_write(i));
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        wr_ready_a = 1'b1;
        wr_ready_b = 1'b1;
        for (int i = 0; i < NP; i++) begin
            mem_y[i]  = '0;
            mem_cb[i] = '0;
            mem_cr[i] = '0;
        end
        #1 rst = 1'b1;
        test_reset();
        test_frame();
        test_back_pressure();
        test_latency_params();
        test_start_handling();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
